// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types for the up/down sweep controller:
// FSM state encoding and sweep mode constants.
package updown_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/updown_cnt_core.sv
// Up/down counter datapath with synchronous load.
// Load wins over enable; the controller guarantees no wrap.
module updown_cnt_core #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + ONE : count - ONE;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: owns the FSM, latched bounds/mode and the
// pass counter; the counter core only loads and steps on command.
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int W  = 3,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic [W-1:0]  cfg_lo,
    input  logic [W-1:0]  cfg_hi,
    input  logic [1:0]    cfg_mode,
    input  logic          cfg_up,
    output logic [W-1:0]  count,
    output logic          dir_up,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] passes
);

    localparam logic [PW-1:0] PASS_MAX = '1;
    localparam logic [PW-1:0] PASS_ONE = PW'(1);

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [1:0]   mode;
    logic         dir_nx;
    logic         err_nx;
    logic         cfg_latch;
    logic         pass_clr;
    logic         pass_inc;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         cnt_en;
    logic         cnt_up;
    logic [W-1:0] endpoint;
    logic         at_end;

    assign endpoint = dir_up ? hi : lo;
    assign at_end   = (count == endpoint);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    updown_cnt_core #(.W(W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dir_up <= 1'b1;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            dir_up <= dir_nx;
            err    <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo   <= '0;
            hi   <= '0;
            mode <= MODE_ONESHOT;
        end else if (cfg_latch) begin
            lo   <= cfg_lo;
            hi   <= cfg_hi;
            mode <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            passes <= '0;
        end else if (pass_clr) begin
            passes <= '0;
        end else if (pass_inc && passes != PASS_MAX) begin
            passes <= passes + PASS_ONE;
        end
    end

    always_comb begin
        state_nx     = state;
        dir_nx       = dir_up;
        err_nx       = 1'b0;
        cfg_latch    = 1'b0;
        pass_clr     = 1'b0;
        pass_inc     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = count;
        cnt_en       = 1'b0;
        cnt_up       = dir_up;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_lo <= cfg_hi) begin
                        cfg_latch    = 1'b1;
                        pass_clr     = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = cfg_up ? cfg_lo : cfg_hi;
                        dir_nx       = cfg_up;
                        state_nx     = RUN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (pause) begin
                    state_nx = HOLD;
                end else begin
                    state_nx = RUN;
                    if (!at_end) begin
                        cnt_en = 1'b1;
                    end else begin
                        pass_inc = 1'b1;
                        unique case (mode)
                            MODE_REPEAT: begin
                                cnt_load     = 1'b1;
                                cnt_load_val = dir_up ? lo : hi;
                            end
                            MODE_PINGPONG: begin
                                // Reverse and take the first step at once
                                dir_nx = ~dir_up;
                                cnt_up = ~dir_up;
                                cnt_en = (lo != hi);
                            end
                            default: begin
                                state_nx = DONE;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench: reference model pushes per-cycle expectations,
// a monitor pops and compares after each rising edge.
module tb_updown_sweep_ctrl;

    typedef struct packed {
        logic [2:0] count;
        logic       dir_up;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] passes;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] cfg_lo = '0;
    logic [2:0] cfg_hi = '0;
    logic [1:0] cfg_mode = '0;
    logic       cfg_up = 1'b1;
    logic [2:0] count;
    logic       dir_up;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] passes;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    int c_lo = 0, c_hi = 7, c_mode = 0;
    bit c_up = 1, c_rst = 1;

    int m_count, m_lo, m_hi, m_mode, m_passes;
    bit m_up, m_active, m_finish, m_err;

    updown_sweep_ctrl #(.W(3), .PW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pause(pause), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .cfg_mode(cfg_mode), .cfg_up(cfg_up), .count(count),
        .dir_up(dir_up), .busy(busy), .done(done), .err(err),
        .passes(passes)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0; m_up = 1; m_active = 0; m_finish = 0;
        m_err = 0; m_passes = 0;
    endtask

    // Behaviour after the coming rising edge, from current inputs
    task automatic model_step();
        int target;
        m_err = 0;
        if (!rst) begin
            model_reset();
        end else if (m_finish) begin
            m_finish = 0;
        end else if (!m_active) begin
            if (start) begin
                if (cfg_lo <= cfg_hi) begin
                    m_lo = int'(cfg_lo); m_hi = int'(cfg_hi);
                    m_mode = int'(cfg_mode); m_up = cfg_up;
                    m_count = m_up ? m_lo : m_hi;
                    m_passes = 0; m_active = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (stop) begin
            m_active = 0;
        end else if (!pause) begin
            target = m_up ? m_hi : m_lo;
            if (m_count != target) begin
                m_count += m_up ? 1 : -1;
            end else begin
                if (m_passes < 15) m_passes++;
                if (m_mode == 1) begin
                    m_count = m_up ? m_lo : m_hi;
                end else if (m_mode == 2) begin
                    m_up = !m_up;
                    if (m_lo != m_hi) m_count += m_up ? 1 : -1;
                end else begin
                    m_active = 0; m_finish = 1;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.count = 3'(m_count);
        e.dir_up = m_up;
        e.busy = m_active | m_finish;
        e.done = m_finish;
        e.err = m_err;
        e.passes = 4'(m_passes);
        sb.push_back(e);
    endtask

    task automatic cyc(input bit st, input bit sp, input bit ps);
        @(negedge clk);
        rst = c_rst; start = st; stop = sp; pause = ps;
        cfg_lo = 3'(c_lo); cfg_hi = 3'(c_hi);
        cfg_mode = 2'(c_mode); cfg_up = c_up;
        model_step();
        push_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic setcfg(input int lo, input int hi, input int md,
                          input bit up);
        c_lo = lo; c_hi = hi; c_mode = md; c_up = up;
    endtask

    // Reset lands between edges; outputs must clear before any clock
    task automatic async_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        #1;
        tests++;
        if (count !== 3'd0 || dir_up !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: count=%0d dir=%b busy=%b want 0/1/0",
                     count, dir_up, busy);
        end
        model_step();
        push_exp();
        c_rst = 0;
        cyc(0, 0, 0);
        c_rst = 1;
    endtask

    initial begin : monitor
        exp_t e;
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n++;
                tests++;
                if (count !== e.count || dir_up !== e.dir_up ||
                    busy !== e.busy || done !== e.done ||
                    err !== e.err || passes !== e.passes) begin
                    fails++;
                    $display("FAIL cyc%0d got c=%0d d=%b b=%b dn=%b e=%b p=%0d want c=%0d d=%b b=%b dn=%b e=%b p=%0d",
                             n, count, dir_up, busy, done, err, passes,
                             e.count, e.dir_up, e.busy, e.done, e.err,
                             e.passes);
                end
            end
        end
    end

    initial begin : stim
        model_reset();
        m_lo = 0; m_hi = 0; m_mode = 0;
        c_rst = 0;
        idle(3);
        c_rst = 1;
        idle(2);

        setcfg(2, 5, 0, 1);
        cyc(1, 0, 0);
        idle(8);

        setcfg(1, 3, 2, 0);
        cyc(1, 0, 0);
        idle(12);
        cyc(0, 1, 0);
        idle(2);

        setcfg(0, 7, 1, 1);
        cyc(1, 0, 0);
        idle(140);
        cyc(0, 1, 0);
        idle(2);

        setcfg(0, 7, 0, 1);
        cyc(1, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        idle(1);
        cyc(0, 1, 0);
        idle(4);

        setcfg(6, 2, 0, 1);
        cyc(1, 0, 0);
        idle(2);
        setcfg(4, 4, 0, 1);
        cyc(1, 0, 0);
        idle(3);
        setcfg(4, 4, 2, 0);
        cyc(1, 0, 0);
        idle(5);
        cyc(0, 1, 0);

        setcfg(0, 7, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        async_reset();
        idle(2);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                setcfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                cyc($urandom_range(0, 9) < 3, $urandom_range(0, 49) < 2,
                    $urandom_range(0, 9) < 2);
            end
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives a parameterised up/down counter through programmed sweeps between a low and a high bound.
- Sweep modes: one-shot, repeat, ping-pong.
- Start/busy/done handshake plus pause and stop controls.
- Sits between the control/test logic and the counter datapath; the controller alone decides load, enable and direction.

Parameters:
- W, 3, counter width in bits.
- PW, 4, width of the pass counter (saturating endpoint-arrival count).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (assert 0, release 1).
- start  in  1  begin sweep; sampled only in IDLE.
- stop  in  1  abort sweep; return to IDLE.
- pause  in  1  hold count while high (RUN/HOLD only).
- cfg_lo  in  W  lower bound.
- cfg_hi  in  W  upper bound.
- cfg_mode  in  2  00 one-shot, 01 repeat, 10 ping-pong, 11 reserved (treated as one-shot).
- cfg_up  in  1  initial direction: 1 up, 0 down.
- count  out  W  counter value.
- dir_up  out  1  current direction.
- busy  out  1  high in RUN, HOLD, DONE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse on rejected start.
- passes  out  PW  endpoint arrivals this sweep, saturating.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, count=0, dir_up=1, busy=0, done=0, err=0, passes=0. Reset mid-sweep aborts immediately.
- States: IDLE, RUN, HOLD, DONE.
- IDLE, start=1, cfg_lo<=cfg_hi:
  - Latch lo, hi, mode, cfg_up; passes=0.
  - Load count = up ? lo : hi; dir_up = cfg_up; go to RUN.
  - Loaded value and busy=1 are visible the cycle after start.
- IDLE, start=1, cfg_lo>cfg_hi: err=1 for one cycle; stay IDLE; count unchanged.
- start outside IDLE: ignored. Latched config is immune to cfg_* changes during a sweep.
- RUN, endpoint = dir_up ? hi : lo.
  - count != endpoint: count <= count±1.
  - count == endpoint: passes++ (saturate at 2^PW-1), then by mode:
    - one-shot: go to DONE, count holds.
    - repeat: count <= start value (lo if up, hi if down), direction unchanged.
    - ping-pong: dir_up toggles; count moves one step in the new direction (holds if lo==hi).
- Bounds arithmetic stays within [lo,hi]; count never wraps modulo 2^W. lo=0/hi=2^W-1 are legal.
- HOLD: entered from RUN when pause=1 (takes priority over the step that cycle). Count and dir frozen. Return to RUN the cycle pause=0; stepping resumes that cycle.
- Priority in RUN/HOLD: stop > pause > step/endpoint action.
- stop in RUN/HOLD/DONE: IDLE next cycle; count and dir_up retained; no done pulse. In DONE the pulse already emitted stands.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE (busy=0). start during DONE is ignored.
- lo==hi: endpoint is true on the first RUN cycle.
  - one-shot: DONE next cycle.
  - repeat / ping-pong: count constant, passes increments each cycle.

Decomposition:
- Shared package:
  - state enum (IDLE/RUN/HOLD/DONE).
  - mode constants MODE_ONESHOT=2'b00, MODE_REPEAT=2'b01, MODE_PINGPONG=2'b10.
- Sub-module updown_cnt_core:
  - W-bit register with synchronous load (load, load_val), enable and up/down inputs.
  - Asynchronous active-low reset to 0.
  - The controller owns only the FSM, latched config and passes.

Test Plan:
- lo=2, hi=5, up, one-shot; start at T0 -> count 2,3,4,5 at T1..T4; done=1 at T5; busy=0 at T6; passes=1.
- lo=1, hi=3, down, ping-pong -> count 3,2,1,2,3,2… from T1; dir_up toggles at the cycles after count=1 and count=3; passes increments at each endpoint.
- lo=0, hi=7, up, repeat -> 0..7 then 0 again the cycle after 7; no done; passes saturates at 15 after 15 arrivals.
- One-shot lo=0, hi=7, pause high at count=3 for 4 cycles -> count stays 3, state HOLD, busy=1; resumes 4 the cycle pause falls. Then stop at count=5 -> IDLE next cycle, count=5, done never pulses.
- cfg_lo=6, cfg_hi=2, start -> err=1 one cycle, busy stays 0, count unchanged. Then lo=hi=4 one-shot -> count=4 at T1, done at T2.
- rst pulsed low mid-sweep (count=4, dir down) -> count=0, dir_up=1, busy=0 immediately, before the next clock edge. start=1 held during RUN has no effect.
